pe_mac_v2: RTL

// - Parametrised systolic PE, next generation of the array PE.
// - Forwards A right and B down with a 1-cycle register stage and propagates enables.
// - Packed-integer dot-product MAC into an N-deep accumulator regfile (one entry per output tile).
// - Drains the regfile down the column through the in_sum/out_sum chain.

---
 rtl/pe_mac_v2.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/pe_mac_v2.sv
// pe_mac_v2: systolic PE with packed-int dot-product MAC and column drain.
// Define PE_SATURATE_EN for signed saturation instead of wrap-around.
module pe_mac_v2 #(
  parameter int DW        = 32,
  parameter int ACCW      = 32,
  parameter int N         = 4,
  parameter int ROW_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enleft,
  input  logic            enup,
  output logic            enright,
  output logic            endown,
  input  logic [DW-1:0]   a_left,
  output logic [DW-1:0]   a_right,
  input  logic [DW-1:0]   in_b_above,
  output logic [DW-1:0]   out_b_below,
  input  logic [1:0]      mode_in,
  output logic [1:0]      mode_out,
  input  logic            clear,
  input  logic [ACCW-1:0] c,
  input  logic            drain_start,
  input  logic            drain_in_valid,
  input  logic            drain_in_last,
  input  logic [ACCW-1:0] in_sum,
  output logic [ACCW-1:0] out_sum,
  output logic            drain_out_valid,
  output logic            drain_out_last,
  output logic            busy,
  output logic            err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = 66 + $clog2(DW);
  localparam int XW = (SW > ACCW) ? SW : ACCW + 2;
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_PASS
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_dptr;
  logic [ACCW-1:0]     r_acc [N];
  logic [ACCW-1:0]     r_sum;
  logic                r_dvalid;
  logic                r_dlast;
  logic                r_err;
  logic                r_enr;
  logic                r_end;
  logic [DW-1:0]       r_a;
  logic [DW-1:0]       r_b;
  logic [1:0]          r_mode;

  logic                w_en;
  logic signed [XW-1:0] w_dot_raw;
  logic [ACCW-1:0]     w_dot;
  logic [ACCW-1:0]     w_base;
  logic signed [XW-1:0] w_sum;
  logic [ACCW-1:0]     w_acc_nx;

  // Sum of sign-extended lane products, kept wide so nothing is lost yet.
  function automatic logic signed [XW-1:0] f_dot(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic [1:0]    m
  );
    logic signed [XW-1:0] s;
    logic signed [63:0]   p32;
    logic signed [31:0]   p16;
    logic signed [15:0]   p8;
    logic signed [7:0]    p4;
    s   = '0;
    p32 = '0;
    p16 = '0;
    p8  = '0;
    p4  = '0;
    unique case (m)
      2'd0: begin
        p32 = $signed(a[31:0]) * $signed(b[31:0]);
        s   = XW'(p32);
      end
      2'd1: begin
        for (int k = 0; k < DW / 16; k++) begin
          p16 = $signed(a[k*16 +: 16]) * $signed(b[k*16 +: 16]);
          s   = s + XW'(p16);
        end
      end
      2'd2: begin
        for (int k = 0; k < DW / 8; k++) begin
          p8 = $signed(a[k*8 +: 8]) * $signed(b[k*8 +: 8]);
          s  = s + XW'(p8);
        end
      end
      2'd3: begin
        for (int k = 0; k < DW / 4; k++) begin
          p4 = $signed(a[k*4 +: 4]) * $signed(b[k*4 +: 4]);
          s  = s + XW'(p4);
        end
      end
    endcase
    return s;
  endfunction

`ifdef PE_SATURATE_EN
  localparam logic signed [XW-1:0] MAXV =
    $signed({{(XW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}});
  localparam logic signed [XW-1:0] MINV =
    $signed({{(XW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}});

  function automatic logic [ACCW-1:0] f_fit(
    input logic signed [XW-1:0] x
  );
    logic signed [XW-1:0] y;
    y = x;
    if (x > MAXV) y = MAXV;
    if (x < MINV) y = MINV;
    return ACCW'(y);
  endfunction
`else
  function automatic logic [ACCW-1:0] f_fit(
    input logic signed [XW-1:0] x
  );
    return ACCW'(x);
  endfunction
`endif

  always_comb begin
    w_en      = enleft & enup;
    w_dot_raw = f_dot(a_left, in_b_above, mode_in);
    w_dot     = f_fit(w_dot_raw);
    w_base    = clear ? c : r_acc[r_ptr];
    w_sum     = XW'($signed(w_base)) + XW'($signed(w_dot));
    w_acc_nx  = f_fit(w_sum);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enr  <= 1'b0;
      r_end  <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= '0;
    end else begin
      r_enr <= enleft;
      r_end <= enup;
      if (enleft) begin
        r_a    <= a_left;
        r_mode <= mode_in;
      end
      if (enup) r_b <= in_b_above;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_dptr   <= '0;
      r_sum    <= '0;
      r_dvalid <= 1'b0;
      r_dlast  <= 1'b0;
      r_err    <= 1'b0;
      for (int i = 0; i < N; i++) r_acc[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_dvalid <= 1'b0;
          r_dlast  <= 1'b0;
          if (w_en) begin
            r_acc[r_ptr] <= w_acc_nx;
            r_ptr        <= r_ptr + PW'(1);
          end
          if (drain_in_valid) r_err <= 1'b1;
          if (drain_start) begin
            r_state <= S_OWN;
            r_dptr  <= '0;
          end
        end
        S_OWN: begin
          r_sum    <= r_acc[r_dptr];
          r_dvalid <= 1'b1;
          r_dlast  <= (ROW_FIRST != 0) && (r_dptr == LAST);
          r_dptr   <= r_dptr + PW'(1);
          if (w_en | drain_start | drain_in_valid) r_err <= 1'b1;
          if (r_dptr == LAST) begin
            r_ptr   <= '0;
            r_state <= (ROW_FIRST != 0) ? S_IDLE : S_PASS;
          end
        end
        S_PASS: begin
          r_dvalid <= drain_in_valid;
          r_dlast  <= drain_in_valid & drain_in_last;
          if (drain_in_valid) begin
            r_sum <= in_sum;
            if (drain_in_last) r_state <= S_IDLE;
          end
          if (w_en | drain_start) r_err <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign enright         = r_enr;
  assign endown          = r_end;
  assign a_right         = r_a;
  assign out_b_below     = r_b;
  assign mode_out        = r_mode;
  assign out_sum         = r_sum;
  assign drain_out_valid = r_dvalid;
  assign drain_out_last  = r_dlast;
  assign busy            = (r_state != S_IDLE);
  assign err             = r_err;

endmodule
